// File: rtl/nibble_gather_sched.sv
// rtl/nibble_gather_sched.sv - word-to-byte nibble gather sequencer; optional in_mask via NIBBLE_GATHER_SCHED_MASK_EN
module nibble_gather_sched #(
  parameter int         NPAIRS                  = 3,
  parameter logic [4:0] CHOICES [2*NPAIRS-1:0]  = '{5'd8, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0},
  localparam int        IDXW                    = (NPAIRS > 1) ? $clog2(NPAIRS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef NIBBLE_GATHER_SCHED_MASK_EN
  input  logic [NPAIRS-1:0] in_mask,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [127:0]      in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic [IDXW-1:0]   out_idx,
  output logic              out_last
);

  // A zero-pair sequencer has nothing to emit; refuse to elaborate it.
  generate
    if (NPAIRS < 1) begin : g_bad_npairs
      $error("nibble_gather_sched: NPAIRS must be >= 1");
    end
  endgenerate

  typedef enum logic {IDLE, EMIT} state_t;

  state_t            state_q, state_d;
  logic [127:0]      word_q,  word_d;
  logic [IDXW-1:0]   idx_q,   idx_d;
  logic [NPAIRS-1:0] mask_q,  mask_d;

  // Pairs still eligible for the latched word, and for the word being offered.
  logic [NPAIRS-1:0] in_mask_c;

  logic              emit_c;
  logic              nxt_found_c;
  logic [IDXW-1:0]   nxt_idx_c;
  logic              first_found_c;
  logic [IDXW-1:0]   first_idx_c;
  logic              last_c;
  logic [7:0]        byte_c;
  logic              in_xfer_c;
  logic              out_xfer_c;

`ifdef NIBBLE_GATHER_SCHED_MASK_EN
  assign in_mask_c = in_mask;
`else
  // Without the mask feature every pair is always emitted.
  assign in_mask_c = '1;
`endif

  // Nibble k of a word sits at bit 4k; the lsb is a 7-bit quantity.
  function automatic logic [3:0] nib(input logic [127:0] w, input logic [4:0] k);
    logic [6:0] lsb;
    lsb = {k, 2'b00};
    return w[lsb +: 4];
  endfunction

  // Lowest eligible pair strictly above the current one; none found means current is last.
  always_comb begin
    nxt_found_c = 1'b0;
    nxt_idx_c   = '0;
    for (int p = NPAIRS - 1; p >= 0; p--) begin
      if (mask_q[p] && (IDXW'(p) > idx_q)) begin
        nxt_found_c = 1'b1;
        nxt_idx_c   = IDXW'(p);
      end
    end
  end

  // Lowest eligible pair of the word on in_data, used as the starting index.
  always_comb begin
    first_found_c = 1'b0;
    first_idx_c   = '0;
    for (int p = NPAIRS - 1; p >= 0; p--) begin
      if (in_mask_c[p]) begin
        first_found_c = 1'b1;
        first_idx_c   = IDXW'(p);
      end
    end
  end

  // Shared gather mux: one byte built from the latched word for the current pair.
  always_comb begin
    byte_c = 8'h00;
    for (int p = 0; p < NPAIRS; p++) begin
      if (idx_q == IDXW'(p)) begin
        byte_c = {nib(word_q, CHOICES[2*p+1]), nib(word_q, CHOICES[2*p])};
      end
    end
  end

  assign emit_c     = (state_q == EMIT);
  assign last_c     = !nxt_found_c;

  // Outputs are forced quiet outside EMIT so idle and reset both read as zero.
  assign out_valid  = emit_c;
  assign out_data   = emit_c ? byte_c : 8'h00;
  assign out_idx    = emit_c ? idx_q  : '0;
  assign out_last   = emit_c & last_c;

  // Accept while idle, or on the edge the final byte leaves, so words run back-to-back.
  assign in_ready   = !emit_c | (last_c & out_ready);
  assign in_xfer_c  = in_valid & in_ready;
  assign out_xfer_c = out_valid & out_ready;

  // Next-state: latch on accept, walk eligible pairs on each byte taken.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
    unique case (state_q)
      IDLE: begin
        if (in_xfer_c) begin
          word_d  = in_data;
          mask_d  = in_mask_c;
          idx_d   = first_idx_c;
          // An all-zero mask consumes the word without emitting anything.
          state_d = first_found_c ? EMIT : IDLE;
        end
      end
      EMIT: begin
        if (out_xfer_c) begin
          if (!last_c) begin
            idx_d = nxt_idx_c;
          end else if (in_xfer_c) begin
            word_d  = in_data;
            mask_d  = in_mask_c;
            idx_d   = first_idx_c;
            state_d = first_found_c ? EMIT : IDLE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset discards any word in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
    end
  end

endmodule

// File: tb/tb_nibble_gather_sched.sv
// tb/tb_nibble_gather_sched.sv - scoreboard bench for nibble_gather_sched; honours NIBBLE_GATHER_SCHED_MASK_EN
module tb_nibble_gather_sched;

  localparam logic [127:0] W  = 128'h0000_0000_0000_0000_FEDC_BA98_7654_3210;
  localparam logic [127:0] WF = {128{1'b1}};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic [2:0]   in_mask = 3'b111;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [7:0]   out_data;
  logic [1:0]   out_idx;
  logic         out_last;

  int vectors = 0;
  int miscompares = 0;

  bit rand_rdy  = 1'b0;
  bit rdy_force = 1'b1;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] idx;
    logic       last;
  } beat_t;

  beat_t q[$];

  // Nibble indices per slot: pair p uses hi = ch[2p+1], lo = ch[2p].
  int ch [6] = '{0, 1, 2, 3, 4, 8};

  nibble_gather_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef NIBBLE_GATHER_SCHED_MASK_EN
    .in_mask   (in_mask),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] nibble(input logic [127:0] w, input int k);
    return 4'((w >> (4 * k)) & 128'hF);
  endfunction

  // Reference: emit selected pairs ascending; last is the highest selected pair.
  task automatic push_word(input logic [127:0] w, input logic [2:0] m);
    int hi;
    beat_t e;
    hi = -1;
    for (int p = 0; p < 3; p++) if (m[p]) hi = p;
    for (int p = 0; p < 3; p++) begin
      if (m[p]) begin
        e.d    = {nibble(w, ch[2*p+1]), nibble(w, ch[2*p])};
        e.idx  = 2'(p);
        e.last = (p == hi);
        q.push_back(e);
      end
    end
  endtask

  // Monitor: checks handshake and byte against the model every cycle, then updates the scoreboard.
  always @(negedge clk) begin
    logic [2:0] m;
    if (!rst_n) begin
      q.delete();
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
      chk("rst_out_data",  {24'd0, out_data},  32'd0);
      chk("rst_out_idx",   {30'd0, out_idx},   32'd0);
      chk("rst_out_last",  {31'd0, out_last},  32'd0);
    end else begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
      chk("in_ready", {31'd0, in_ready},
          {31'd0, (q.size() == 0) || (q.size() == 1 && out_ready)});
      if (q.size() != 0 && out_valid) begin
        chk("out_data", {24'd0, out_data}, {24'd0, q[0].d});
        chk("out_idx",  {30'd0, out_idx},  {30'd0, q[0].idx});
        chk("out_last", {31'd0, out_last}, {31'd0, q[0].last});
        if (out_ready) void'(q.pop_front());
      end
`ifdef NIBBLE_GATHER_SCHED_MASK_EN
      m = in_mask;
`else
      m = 3'b111;
`endif
      if (in_valid && in_ready) push_word(in_data, m);
    end
  end

  // Consumer ready: forced value or random back-pressure.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_force;
    end
  end

  // Offer a word and wait (bounded) for its accept edge; leaves in_valid high.
  task automatic send(input logic [127:0] w, input logic [2:0] m);
    int n;
    in_data  = w;
    in_mask  = m;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      miscompares++;
      $display("FAIL accept_timeout: in_ready stuck 0 expected 1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(posedge clk);
    #1;
    while (out_valid && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    vectors++;
    if (out_valid) begin
      miscompares++;
      $display("FAIL drain_timeout: out_valid 1 expected 0");
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // Plain word, consumer always ready.
    rdy_force = 1'b1;
    send(W, 3'b111);
    in_valid = 1'b0;
    drain();

    // Stall three cycles on byte 1.
    send(W, 3'b111);
    in_valid = 1'b0;
    idle(1);
    rdy_force = 1'b0;
    idle(3);
    rdy_force = 1'b1;
    drain();

    // Back-to-back words with in_valid held.
    send(W, 3'b111);
    send(WF, 3'b111);
    in_valid = 1'b0;
    drain();

    // Reset while byte 1 is pending.
    send(W, 3'b111);
    in_valid = 1'b0;
    idle(1);
    rdy_force = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("reset_immediate_out_valid", {31'd0, out_valid}, 32'd0);
    idle(2);
    rst_n = 1'b1;
    rdy_force = 1'b1;
    idle(4);

`ifdef NIBBLE_GATHER_SCHED_MASK_EN
    send(W, 3'b101);
    in_valid = 1'b0;
    drain();
    send(W, 3'b000);
    in_valid = 1'b0;
    idle(4);
`endif

    // Random words with random back-pressure and gaps.
    rand_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      logic [2:0] m;
`ifdef NIBBLE_GATHER_SCHED_MASK_EN
      m = 3'($urandom_range(0, 7));
`else
      m = 3'b111;
`endif
      send({$urandom, $urandom, $urandom, $urandom}, m);
      if ($urandom_range(0, 1) == 0) begin
        in_valid = 1'b0;
        idle($urandom_range(0, 4));
      end
    end
    in_valid = 1'b0;
    drain();
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
